mag_agc_ctrl: RTL and testbench

- Closed-loop gain controller for the magnitude path of the mag/phase gain RFNoC block.
- Passively taps the squelched-magnitude AXI stream and averages it over a programmable window.
- Steps the 16-bit mag gain toward a target level with hysteresis and saturation.
- Applies new gains only on packet boundaries, so gain never changes inside a CHDR packet. Also owns the squelch level register.

---
 rtl/mag_agc_pkg.sv | 21 ++
 rtl/agc_window_accum.sv | 42 ++++
 rtl/mag_agc_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mag_agc_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mag_agc_pkg.sv
// Shared constants, state encoding and sizing helper for the magnitude AGC loop.
package mag_agc_pkg;

    localparam int unsigned SR_CTRL    = 0;
    localparam int unsigned SR_TARGET  = 1;
    localparam int unsigned SR_STEP    = 2;
    localparam int unsigned SR_GAIN    = 3;
    localparam int unsigned SR_SQUELCH = 4;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAccum   = 3'd1,
        StDecide  = 3'd2,
        StWaitEop = 3'd3
    } agc_state_e;

    function automatic int unsigned acc_width(input int unsigned win_log2_max);
        return 16 + win_log2_max;
    endfunction

endpackage

// File: rtl/agc_window_accum.sv
// Windowed magnitude accumulator: sums beats over 2^win_log2 samples and exposes the mean.
module agc_window_accum
    import mag_agc_pkg::*;
#(
    parameter int unsigned WIN_LOG2_MAX = 12
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        clear,
    input  logic        beat_en,
    input  logic [15:0] data,
    input  logic [3:0]  win_log2,
    output logic        done,
    output logic [15:0] mean
);

    localparam int unsigned AccW = acc_width(WIN_LOG2_MAX);
    localparam int unsigned CntW = WIN_LOG2_MAX + 1;

    logic [AccW-1:0] acc_q;
    logic [AccW-1:0] acc_shift;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_last;

    always_comb begin
        cnt_last  = (CntW'(1) << win_log2) - CntW'(1);
        acc_shift = acc_q >> win_log2;
        mean      = acc_shift[15:0];
        done      = beat_en && (cnt_q == cnt_last);
    end

    always_ff @(posedge clk) begin
        if (!aresetn || clear) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (beat_en) begin
            acc_q <= acc_q + AccW'(data);
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/mag_agc_ctrl.sv
// Closed-loop mag gain controller: averages the tapped magnitude stream, steps gain toward
// a target with hysteresis, and only commits new gains on packet boundaries.
module mag_agc_ctrl
    import mag_agc_pkg::*;
#(
    parameter int unsigned SR_BASE      = 196,
    parameter int unsigned WIN_LOG2_MAX = 12,
    parameter logic [15:0] GAIN_MIN     = 16'h0010,
    parameter logic [15:0] GAIN_MAX     = 16'hFFF0,
    parameter logic [15:0] GAIN_INIT    = 16'h1000
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [15:0] mag_tdata,
    input  logic        mag_tlast,
    input  logic        mag_tvalid,
    input  logic        mag_tready,
    output logic [15:0] gain,
    output logic [15:0] squelch_level,
    output logic        gain_update,
    output logic [63:0] rb_data
);

    logic        enable_q, hold_q;
    logic [3:0]  win_cfg_q, win_q, win_wr;
    logic [15:0] target_q, step_q, hyst_q, squelch_q;
    logic [15:0] gain_q, pending_q, last_mean_q;
    logic        gain_update_q;
    agc_state_e  state_q;

    logic        wr_ctrl, wr_target, wr_step, wr_gain, wr_squelch;
    logic        beat, beat_en, acc_clear, win_done;
    logic [15:0] mean;
    logic [16:0] mean_x, hi_x, lo_x, down_x, up_x;
    logic [15:0] dec_pending;
    logic        dec_flag;

    always_comb begin
        wr_ctrl    = set_stb && (set_addr == 8'(SR_BASE + SR_CTRL));
        wr_target  = set_stb && (set_addr == 8'(SR_BASE + SR_TARGET));
        wr_step    = set_stb && (set_addr == 8'(SR_BASE + SR_STEP));
        wr_gain    = set_stb && (set_addr == 8'(SR_BASE + SR_GAIN));
        wr_squelch = set_stb && (set_addr == 8'(SR_BASE + SR_SQUELCH));
        win_wr     = (set_data[7:4] > 4'(WIN_LOG2_MAX)) ? 4'(WIN_LOG2_MAX) : set_data[7:4];
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            enable_q  <= 1'b0;
            hold_q    <= 1'b0;
            win_cfg_q <= '0;
            target_q  <= '0;
            step_q    <= '0;
            hyst_q    <= '0;
            squelch_q <= '0;
        end else begin
            if (wr_ctrl) begin
                enable_q  <= set_data[0];
                hold_q    <= set_data[1];
                win_cfg_q <= win_wr;
            end
            if (wr_target)  target_q  <= set_data[15:0];
            if (wr_step) begin
                step_q <= set_data[15:0];
                hyst_q <= set_data[31:16];
            end
            if (wr_squelch) squelch_q <= set_data[15:0];
        end
    end

    // A manual gain write while running flushes the current window.
    always_comb begin
        beat      = mag_tvalid && mag_tready;
        beat_en   = beat && !hold_q && (state_q == StAccum || state_q == StWaitEop);
        acc_clear = !enable_q || state_q == StIdle || state_q == StDecide || wr_gain;
    end

    agc_window_accum #(
        .WIN_LOG2_MAX (WIN_LOG2_MAX)
    ) u_accum (
        .clk      (clk),
        .aresetn  (aresetn),
        .clear    (acc_clear),
        .beat_en  (beat_en),
        .data     (mag_tdata),
        .win_log2 (win_q),
        .done     (win_done),
        .mean     (mean)
    );

    // 17-bit compares so target+hyst and gain+step cannot wrap.
    always_comb begin
        mean_x = {1'b0, mean};
        hi_x   = {1'b0, target_q} + {1'b0, hyst_q};
        lo_x   = mean_x + {1'b0, hyst_q};
        down_x = {1'b0, gain_q} - {1'b0, step_q};
        up_x   = {1'b0, gain_q} + {1'b0, step_q};
        dec_pending = gain_q;
        dec_flag    = 1'b0;
        if (mean_x > hi_x) begin
            dec_flag    = 1'b1;
            dec_pending = (down_x[16] || down_x[15:0] < GAIN_MIN) ? GAIN_MIN : down_x[15:0];
        end else if (lo_x < {1'b0, target_q}) begin
            dec_flag    = 1'b1;
            dec_pending = (up_x > {1'b0, GAIN_MAX}) ? GAIN_MAX : up_x[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q       <= StIdle;
            gain_q        <= GAIN_INIT;
            pending_q     <= '0;
            win_q         <= '0;
            last_mean_q   <= '0;
            gain_update_q <= 1'b0;
        end else begin
            gain_update_q <= 1'b0;
            if (!enable_q) begin
                state_q <= StIdle;
                if (wr_gain && set_data[15:0] != gain_q) begin
                    gain_q        <= set_data[15:0];
                    gain_update_q <= 1'b1;
                end
            end else if (wr_gain && state_q != StIdle) begin
                pending_q <= set_data[15:0];
                state_q   <= StWaitEop;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (wr_gain && set_data[15:0] != gain_q) begin
                            gain_q        <= set_data[15:0];
                            gain_update_q <= 1'b1;
                        end
                        win_q   <= win_cfg_q;
                        state_q <= StAccum;
                    end
                    StAccum: begin
                        if (win_done) state_q <= StDecide;
                    end
                    StDecide: begin
                        last_mean_q <= mean;
                        pending_q   <= dec_pending;
                        win_q       <= win_cfg_q;
                        state_q     <= dec_flag ? StWaitEop : StAccum;
                    end
                    StWaitEop: begin
                        if (beat && mag_tlast) begin
                            if (pending_q != gain_q) begin
                                gain_q        <= pending_q;
                                gain_update_q <= 1'b1;
                            end
                            state_q <= win_done ? StDecide : StAccum;
                        end else if (win_done) begin
                            state_q <= StDecide;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign gain          = gain_q;
    assign squelch_level = squelch_q;
    assign gain_update   = gain_update_q;
    assign rb_data       = {gain_q, last_mean_q, target_q, 13'b0, state_q};

endmodule

// File: tb/tb_mag_agc_ctrl.sv
// Directed bench for mag_agc_ctrl: reset, step down, deadband, saturation, EOP race, disable.
module tb_mag_agc_ctrl;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [15:0] mag_tdata;
    logic        mag_tlast, mag_tvalid, mag_tready;
    logic [15:0] gain, squelch_level;
    logic        gain_update;
    logic [63:0] rb_data;

    int errors = 0;
    int checks = 0;
    int upd_cnt = 0;
    int upd_base;
    logic seen_wait = 1'b0;

    always #5 clk = ~clk;

    mag_agc_ctrl dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .set_stb       (set_stb),
        .set_addr      (set_addr),
        .set_data      (set_data),
        .mag_tdata     (mag_tdata),
        .mag_tlast     (mag_tlast),
        .mag_tvalid    (mag_tvalid),
        .mag_tready    (mag_tready),
        .gain          (gain),
        .squelch_level (squelch_level),
        .gain_update   (gain_update),
        .rb_data       (rb_data)
    );

    // Posedge sampling sees the previous cycle's registered values.
    always @(posedge clk) begin
        if (gain_update === 1'b1) upd_cnt = upd_cnt + 1;
        if (rb_data[2:0] === 3'd3) seen_wait = 1'b1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int unsigned k, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = 8'(196 + k);
        set_data = d;
        tick();
        set_stb  = 1'b0;
    endtask

    task automatic beat(input logic [15:0] d, input logic last);
        mag_tvalid = 1'b1;
        mag_tready = 1'b1;
        mag_tdata  = d;
        mag_tlast  = last;
        tick();
    endtask

    task automatic idle();
        mag_tvalid = 1'b0;
        mag_tlast  = 1'b0;
    endtask

    initial begin
        // Reset with stimulus active, including a gain write and beats.
        aresetn    = 1'b0;
        set_stb    = 1'b1;
        set_addr   = 8'd199;
        set_data   = 32'h5555;
        mag_tvalid = 1'b1;
        mag_tready = 1'b1;
        mag_tdata  = 16'd500;
        mag_tlast  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_gain", 64'(gain), 64'h1000);
            chk("reset_squelch", 64'(squelch_level), 64'h0);
            chk("reset_upd", 64'(gain_update), 64'h0);
            chk("reset_state", 64'(rb_data[2:0]), 64'h0);
        end
        aresetn = 1'b1;
        set_stb = 1'b0;
        idle();
        tick();
        tick();
        chk("reset_no_pulse", 64'(upd_cnt), 64'd0);

        wr(4, 32'h0000_1234);
        chk("squelch_next_cycle", 64'(squelch_level), 64'h1234);

        // Loud input: mean 2000 vs target 1000 +/- 50 steps gain down by 0x100.
        wr(1, 32'd1000);
        chk("target_rb", 64'(rb_data[31:16]), 64'd1000);
        wr(2, {16'd50, 16'h0100});
        wr(0, 32'h41);
        tick();
        chk("loud_accum_state", 64'(rb_data[2:0]), 64'd1);
        upd_base = upd_cnt;
        for (int i = 1; i <= 32; i++) begin
            beat(16'd2000, i == 32);
            if (i == 31) chk("loud_gain_before_eop", 64'(gain), 64'h1000);
        end
        chk("loud_gain_after_eop", 64'(gain), 64'h0F00);
        chk("loud_upd_pulse", 64'(gain_update), 64'h1);
        chk("loud_last_mean", 64'(rb_data[47:32]), 64'd2000);
        idle();
        tick();
        tick();
        chk("loud_single_pulse", 64'(upd_cnt - upd_base), 64'd1);
        wr(0, 32'h40);
        tick();

        // Deadband: mean 1040 sits inside 1000 +/- 50 for four windows.
        wr(0, 32'h41);
        tick();
        seen_wait = 1'b0;
        upd_base  = upd_cnt;
        for (int i = 1; i <= 68; i++) beat(16'd1040, (i % 8) == 0);
        idle();
        chk("dead_state_accum", 64'(rb_data[2:0]), 64'd1);
        tick();
        chk("dead_gain", 64'(gain), 64'h0F00);
        chk("dead_mean", 64'(rb_data[47:32]), 64'd1040);
        chk("dead_no_pulse", 64'(upd_cnt - upd_base), 64'd0);
        chk("dead_no_wait", 64'(seen_wait), 64'd0);
        wr(0, 32'h40);
        tick();

        // Saturation: silent input with a large step clamps at GAIN_MAX.
        wr(3, 32'hF000);
        chk("sat_manual_gain", 64'(gain), 64'hF000);
        wr(2, {16'd50, 16'h4000});
        wr(0, 32'h41);
        tick();
        tick();
        upd_base = upd_cnt;
        for (int i = 1; i <= 60; i++) begin
            beat(16'd0, (i % 4) == 0);
            if (i == 20) chk("sat_first_eop", 64'(gain), 64'hFFF0);
        end
        idle();
        tick();
        tick();
        chk("sat_hold_max", 64'(gain), 64'hFFF0);
        chk("sat_one_pulse", 64'(upd_cnt - upd_base), 64'd1);
        wr(0, 32'h40);
        tick();

        // EOP race: tlast on the completing beat (t) and on t+1 must not apply the gain.
        wr(3, 32'h1000);
        chk("race_manual_gain", 64'(gain), 64'h1000);
        wr(2, {16'd50, 16'h0100});
        wr(0, 32'h41);
        tick();
        for (int i = 1; i <= 21; i++) begin
            beat(16'd2000, i == 16 || i == 17 || i == 21);
            if (i == 16) chk("race_gain_t", 64'(gain), 64'h1000);
            if (i == 17) chk("race_gain_t1", 64'(gain), 64'h1000);
            if (i == 20) begin
                chk("race_gain_wait", 64'(gain), 64'h1000);
                chk("race_state_wait", 64'(rb_data[2:0]), 64'd3);
            end
        end
        chk("race_gain_applied", 64'(gain), 64'h0F00);

        // Reach WAIT_EOP again, then disable and confirm the pending gain is dropped.
        for (int i = 22; i <= 35; i++) beat(16'd2000, 1'b0);
        chk("dis_in_wait", 64'(rb_data[2:0]), 64'd3);
        idle();
        wr(0, 32'h40);
        tick();
        chk("dis_idle", 64'(rb_data[2:0]), 64'd0);
        upd_base = upd_cnt;
        for (int i = 0; i < 100; i++) beat(16'd2000, 1'b1);
        idle();
        tick();
        chk("dis_gain_held", 64'(gain), 64'h0F00);
        chk("dis_no_pulse", 64'(upd_cnt - upd_base), 64'd0);
        wr(3, 32'h2222);
        chk("dis_manual_gain", 64'(gain), 64'h2222);
        chk("dis_manual_pulse", 64'(gain_update), 64'h1);
        tick();
        chk("dis_pulse_one_cycle", 64'(gain_update), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
